store_hash_queue: RTL
=====================

// Module: store_hash_queue
// PURPOSE
// - In-order tracking queue for in-flight stores in the load/store unit.
// - Sits directly downstream of the 4-bit address hash generator.
// - Each issued store deposits its hash and ID on push; entries leave in order on commit.
// - Each load's hash is compared against every live entry to flag a potential RAW conflict.
// - Hashing is conservative: aliasing may give false positives, never false negatives.
// PARAMETERS
// - DEPTH   4  number of store entries; power of two, 2..16
// - HASH_W  4  address-hash width; matches the hash generator output
// - ID_W    3  store ID width, returned to the LSU for forwarding/wait
// PORTS
// - clk             in   1       clock
// - rst             in   1       asynchronous, active-high reset
// - push_valid      in   1       store issue request
// - push_ready      out  1       queue can accept: !full || pop_valid
// - push_hash       in   HASH_W  address hash of the issuing store
// - push_id         in   ID_W    ID of the issuing store
// - pop_valid       in   1       oldest store committed; remove head
// - flush           in   1       discard all entries (pipeline flush)
// - load_valid      in   1       load presenting a hash for checking
// - load_hash       in   HASH_W  address hash of the load
// - conflict        out  1       load hash matches a live entry or accepted push
// - conflict_id     out  ID_W    ID of youngest matching store (fwd option only)
// - empty           out  1       no live entries
// - full            out  1       DEPTH live entries
// BEHAVIOUR
// - State: head/tail pointers (log2 DEPTH bits, wrap modulo DEPTH); count (log2 DEPTH+1 bits).
// - State: per-entry {valid, hash, id}.
// - Reset: pointers = 0, count = 0, all entry valids = 0.
// - Reset values seen at outputs: empty = 1, full = 0, push_ready = 1, conflict = 0, conflict_id = 0.
// - Push: accepted when push_valid && push_ready.
//   - Writes the tail entry, advances tail.
//   - The entry takes part in compares from the next cycle on.
// - Pop: pop_valid && !empty clears the head valid and advances head.
//   - pop_valid while empty is ignored; no pointer or count change.
// - Push and pop together: allowed even when full.
//   - Head and tail both advance; count is unchanged.
//   - When full, push_ready = 1 only because pop_valid = 1 in that cycle.
// - Push when full and no pop: push_ready = 0; no write; state unchanged.
// - Compare is combinational, zero cycles: conflict = load_valid && (any live entry hash == load_hash).
//   - An accepted same-cycle push also takes part when push_hash == load_hash.
//   - The head being popped in the same cycle still takes part (conservative).
// - Flush: synchronous; takes priority over push and pop in the same cycle.
//   - Next cycle: all valids = 0, head = tail = 0, count = 0.
//   - conflict still computes from pre-flush contents in the flush cycle.
// - empty = (count == 0); full = (count == DEPTH); both driven directly from count.
// - Asynchronous reset mid-operation returns all state to reset values immediately.
// - No entry survives reset.
// CONFIGURATION
// - Macro STORE_HASH_QUEUE_FWD_EN.
// - Defined: conflict_id = ID of the youngest match in age order, tail-1 back to head, wrapping.
//   - An accepted same-cycle matching push is youngest of all.
//   - conflict_id = 0 when conflict = 0.
// - Not defined: conflict_id tied to 0; no priority logic synthesized.
//   - conflict is unchanged.
// TESTING
// - Reset, then idle: empty = 1, full = 0, push_ready = 1, conflict = 0 with load_valid = 1 and hash 4'h5.
// - Push 4 stores (hash 1,2,3,4; id 0..3), no pop: full = 1, push_ready = 0.
//   - 5th push ignored; load hash 4'h3 -> conflict = 1, conflict_id = 2 (FWD_EN).
// - Full queue, push (hash 9, id 4) with pop in the same cycle: accepted, count stays 4.
//   - Next cycle, load hash 4'h1 -> conflict = 0; load hash 4'h9 -> conflict = 1, conflict_id = 4.
// - Live entries hash 4'h7 id 1 and hash 4'h7 id 3, plus a same-cycle push hash 4'h7 id 5, load 4'h7:
//   - conflict = 1, conflict_id = 5 (FWD_EN).
//   - Repeat without the push: conflict_id = 3.
//   - Without FWD_EN: conflict_id = 0.
// - Wrap-around: 10 push/pop pairs with random hashes.
//   - Pointers wrap; a scoreboard model matches conflict on every cycle.
// - Flush with push and pop asserted: next cycle empty = 1, count = 0.
//   - Load with any hash -> conflict = 0.
//   - Assert rst mid-burst: outputs reach reset values without waiting for a clock edge.

Source files
------------

// File: rtl/store_hash_queue_if.sv
// Bundle of store-issue, commit, flush and load-check signals for store_hash_queue.
// The LSU side uses the master modport; the queue itself uses the slave modport.
interface store_hash_queue_if #(
    parameter int HASH_W = 4,
    parameter int ID_W   = 3
);
    logic              push_valid;
    logic              push_ready;
    logic [HASH_W-1:0] push_hash;
    logic [ID_W-1:0]   push_id;
    logic              pop_valid;
    logic              flush;
    logic              load_valid;
    logic [HASH_W-1:0] load_hash;
    logic              conflict;
    logic [ID_W-1:0]   conflict_id;
    logic              empty;
    logic              full;

    modport master (
        output push_valid, push_hash, push_id, pop_valid, flush, load_valid, load_hash,
        input  push_ready, conflict, conflict_id, empty, full
    );

    modport slave (
        input  push_valid, push_hash, push_id, pop_valid, flush, load_valid, load_hash,
        output push_ready, conflict, conflict_id, empty, full
    );
endinterface

// File: rtl/store_hash_queue.sv
// In-order queue of in-flight store hashes with a combinational RAW conflict check.
// Define STORE_HASH_QUEUE_FWD_EN to report the ID of the youngest matching store.
module store_hash_queue #(
    parameter int DEPTH  = 4,
    parameter int HASH_W = 4,
    parameter int ID_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    store_hash_queue_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [HASH_W-1:0] hash_q [DEPTH];
    logic [HASH_W-1:0] hash_d [DEPTH];
    logic [ID_W-1:0]   id_q [DEPTH];
    logic [ID_W-1:0]   id_d [DEPTH];

    logic              empty;
    logic              full;
    logic              push_ready;
    logic              push_fire;
    logic              pop_fire;
    logic [DEPTH-1:0]  hit;
    logic              push_hit;
    logic              conflict;

    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == CNT_FULL);
        push_ready = !full || bus.pop_valid;
        push_fire  = bus.push_valid && push_ready;
        pop_fire   = bus.pop_valid && !empty;
    end

    // A head being popped this cycle still counts, keeping the check conservative.
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = valid_q[i] && (hash_q[i] == bus.load_hash);
        end
        push_hit = push_fire && (bus.push_hash == bus.load_hash);
        conflict = bus.load_valid && ((|hit) || push_hit);
    end

`ifdef STORE_HASH_QUEUE_FWD_EN
    logic [PTR_W-1:0] age_idx;
    logic [ID_W-1:0]  fwd_id;

    // Walk from oldest to youngest so the last match seen is the youngest.
    always_comb begin
        fwd_id  = '0;
        age_idx = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            age_idx = head_q + PTR_W'(k);
            if (hit[age_idx]) begin
                fwd_id = id_q[age_idx];
            end
        end
        if (push_hit) begin
            fwd_id = bus.push_id;
        end
        bus.conflict_id = conflict ? fwd_id : '0;
    end
`else
    assign bus.conflict_id = '0;
`endif

    assign bus.conflict   = conflict;
    assign bus.empty      = empty;
    assign bus.full       = full;
    assign bus.push_ready = push_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        hash_d  = hash_q;
        id_d    = id_q;
        if (bus.flush) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Pop before push so a full-queue push into the freed slot stays valid.
            if (pop_fire) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + PTR_ONE;
            end
            if (push_fire) begin
                valid_d[tail_q] = 1'b1;
                hash_d[tail_q]  = bus.push_hash;
                id_d[tail_q]    = bus.push_id;
                tail_d          = tail_q + PTR_ONE;
            end
            case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                hash_q[i] <= '0;
                id_q[i]   <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            hash_q  <= hash_d;
            id_q    <= id_d;
        end
    end
endmodule
